// File: rtl/servo_pwm_channels.sv
// servo_pwm_channels: N-channel servo pulse generator with frame-synchronous position updates
// Ports: clk/rst_n (async active-low) clock and reset; clkdiv divided tick clock (same domain);
//        wr_en/wr_ch/wr_pos shadow position write; en per-channel enable (sampled at frame boundary);
//        pwm_out registered pulses; frame_start one-cycle frame marker; wr_err bad-channel write pulse.
module servo_pwm_channels #(
    parameter int N_CH        = 8,
    parameter int CH_W        = 3,
    parameter int BASE_TICKS  = 64,
    parameter int FRAME_TICKS = 2560,
    parameter int CNT_W       = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clkdiv,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [7:0]      wr_pos,
    input  logic [N_CH-1:0] en,
    output logic [N_CH-1:0] pwm_out,
    output logic            frame_start,
    output logic            wr_err
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_TICKS);

    logic             clkdiv_q, tick, tick_q, wrap, boundary;
    logic [CNT_W-1:0] fcnt;
    logic [7:0]       shadow  [N_CH];
    logic [7:0]       pos_act [N_CH];
    logic [N_CH-1:0]  en_act, next_pwm;

    // clkdiv_q resets high so a divider already high at reset release is not a tick
    assign tick     = clkdiv & ~clkdiv_q;
    assign wrap     = fcnt == LAST;
    assign boundary = tick & wrap;

    always_comb begin
        next_pwm = '0;
        for (int i = 0; i < N_CH; i++)
            next_pwm[i] = en_act[i] & (fcnt < BASE + CNT_W'(pos_act[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q    <= 1'b1;
            tick_q      <= 1'b0;
            fcnt        <= LAST;
            en_act      <= '0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i]  <= 8'd128;
                pos_act[i] <= 8'd0;
            end
        end else begin
            clkdiv_q    <= clkdiv;
            tick_q      <= tick;
            pwm_out     <= next_pwm;
            frame_start <= (fcnt == '0) & tick_q;
            wr_err      <= wr_en & (int'(wr_ch) >= N_CH);
            if (tick)
                fcnt <= wrap ? '0 : fcnt + 1'b1;
            // active registers take the pre-write shadow when a write lands on the boundary
            if (boundary)
                en_act <= en;
            for (int i = 0; i < N_CH; i++) begin
                if (boundary)
                    pos_act[i] <= shadow[i];
                if (wr_en && wr_ch == CH_W'(i))
                    shadow[i] <= wr_pos;
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_channels.sv
// tb_servo_pwm_channels: directed bench for servo_pwm_channels (8-channel and 6-channel instances)
module tb_servo_pwm_channels;
    logic       clk = 1'b0;
    logic       rst_n, clkdiv, wr_en, div_run;
    logic [2:0] wr_ch;
    logic [7:0] wr_pos;
    logic [7:0] en;
    logic [7:0] pwm_out;
    logic [5:0] pwm6;
    logic       frame_start, wr_err, fs6, err6;

    int total = 0;
    int bad = 0;
    int h8[8], w8[8], h6[6], w6[6];
    int since = 0;
    int period = 0;

    servo_pwm_channels #(.N_CH(8), .CH_W(3), .BASE_TICKS(64), .FRAME_TICKS(400), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .en(en), .pwm_out(pwm_out), .frame_start(frame_start), .wr_err(wr_err)
    );

    servo_pwm_channels #(.N_CH(6), .CH_W(3), .BASE_TICKS(64), .FRAME_TICKS(400), .CNT_W(12)) dut6 (
        .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .en(en[5:0]), .pwm_out(pwm6), .frame_start(fs6), .wr_err(err6)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        if (div_run) clkdiv = ~clkdiv;
    end

    // per-frame high-time counters, snapshotted at each frame_start
    always @(negedge clk) begin
        if (frame_start) begin
            for (int i = 0; i < 8; i++) begin w8[i] = h8[i]; h8[i] = int'(pwm_out[i]); end
            for (int i = 0; i < 6; i++) begin w6[i] = h6[i]; h6[i] = int'(pwm6[i]); end
            period = since;
            since = 1;
        end else begin
            for (int i = 0; i < 8; i++) h8[i] += int'(pwm_out[i]);
            for (int i = 0; i < 6; i++) h6[i] += int'(pwm6[i]);
            since++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_fs();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (frame_start) begin
                #1;
                return;
            end
        end
        chk("frame_start_timeout", 0, 1);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [7:0] pos);
        @(posedge clk);
        #1 wr_en = 1'b1; wr_ch = ch; wr_pos = pos;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clkdiv = 1'b0; div_run = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_pos = '0; en = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_pwm6", pwm6, 0);
        rst_n = 1'b1;
        div_run = 1'b1;
        wait_fs();
        chk("f1_rise", pwm_out, 8'hFF);
        wait_fs();
        chk("f1_w0", w8[0], 384);
        chk("f1_w7", w8[7], 384);
        chk("period", period, 800);
        repeat (100) @(posedge clk);
        wr(3'd0, 8'd0);
        wr(3'd1, 8'd255);
        wr(3'd7, 8'd10);
        wait_fs();
        chk("f2_w0", w8[0], 384);
        chk("f2_w1", w8[1], 384);
        chk("f2_w7", w8[7], 384);
        repeat (798) @(posedge clk);
        #1 wr_en = 1'b1; wr_ch = 3'd2; wr_pos = 8'd200;
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_fs();
        chk("f3_w0", w8[0], 128);
        chk("f3_w1", w8[1], 638);
        chk("f3_w7", w8[7], 148);
        chk("f3_w2", w8[2], 384);
        repeat (50) @(posedge clk);
        #1 wr_en = 1'b1; wr_ch = 3'd7; wr_pos = 8'd10;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        chk("err6_hi", err6, 1);
        chk("err8_lo", wr_err, 0);
        @(negedge clk);
        chk("err6_lo", err6, 0);
        wait_fs();
        chk("f4_w2_bnd", w8[2], 384);
        chk("f4_d6_w0", w6[0], 128);
        chk("f4_d6_w1", w6[1], 638);
        chk("f4_d6_w3", w6[3], 384);
        repeat (100) @(posedge clk);
        #1 en[3] = 1'b0;
        wait_fs();
        chk("f5_w3", w8[3], 384);
        chk("f5_w2", w8[2], 528);
        chk("f5_d6_w2", w6[2], 528);
        chk("f5_d6_w1", w6[1], 638);
        chk("f5_w7", w8[7], 148);
        chk("f6_rise", pwm_out, 8'hF7);
        repeat (100) @(posedge clk);
        #1 en[3] = 1'b1;
        wait_fs();
        chk("f6_w3_off", w8[3], 0);
        wait_fs();
        chk("f7_w3_on", w8[3], 384);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_pwm", pwm_out, 8'hFF);
        div_run = 1'b0;
        clkdiv = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_pwm", pwm_out, 0);
        chk("async_pwm6", pwm6, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_fs", frame_start, 0);
            chk("hold_pwm", pwm_out, 0);
        end
        clkdiv = 1'b0;
        div_run = 1'b1;
        wait_fs();
        chk("g1_rise", pwm_out, 8'hFF);
        wait_fs();
        chk("g1_w0", w8[0], 384);
        chk("g1_w1", w8[1], 384);
        chk("g1_w2", w8[2], 384);
        chk("g1_w7", w8[7], 384);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/servo_pwm_channels.md
# servo_pwm_channels

N-channel servo pulse generator driven by the 128 kHz divided clock from the frequency divider, in the same clock domain. Each channel holds an 8-bit position and emits one high pulse per 20 ms frame, with width BASE_TICKS + position ticks (0.5–2.49 ms at defaults). Position writes go to shadow registers and take effect only at a frame boundary, so a pulse never glitches mid-frame.

## Interface
- N_CH, 8, number of servo channels (1..16)
- CH_W, 3, width of wr_ch; must satisfy 2^CH_W >= N_CH
- BASE_TICKS, 64, minimum pulse width in ticks (64 = 0.5 ms at 128 kHz)
- FRAME_TICKS, 2560, frame length in ticks (2560 = 20 ms); must be > BASE_TICKS + 255
- CNT_W, 12, frame counter width; must hold FRAME_TICKS-1
- clk  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- clkdiv  in  1  divided clock from the frequency divider, synchronous to clk
- wr_en  in  1  position write strobe, one write per cycle
- wr_ch  in  CH_W  channel index for the write
- wr_pos  in  8  new position, 0..255
- en  in  N_CH  per-channel enable, sampled at frame boundary
- pwm_out  out  N_CH  servo pulse outputs, registered
- frame_start  out  1  one-cycle pulse aligned with the first cycle of each frame
- wr_err  out  1  one-cycle pulse when wr_ch >= N_CH

## Operation
- Tick detect: clkdiv_q <= clkdiv; tick = clkdiv & ~clkdiv_q. clkdiv_q resets to 1, so clkdiv high at reset release makes no tick.
- Frame counter fcnt: resets to FRAME_TICKS-1. On tick it goes to fcnt+1, or to 0 when fcnt == FRAME_TICKS-1 (wrap). It holds when there is no tick.
- Frame boundary is the tick that wraps fcnt to 0. On it, pos_act[i] <= shadow[i] and en_act[i] <= en[i] for all i. The first tick after reset is therefore a frame boundary.
- Write: wr_en and wr_ch < N_CH sets shadow[wr_ch] <= wr_pos. With wr_ch >= N_CH, shadow is unchanged and wr_err <= 1 for one cycle. wr_err is 0 otherwise.
- Write in the same cycle as a boundary: the active register captures the old shadow value. The new value applies from the next frame.
- Pulse compare: next_pwm[i] = en_act[i] & (fcnt < BASE_TICKS + pos_act[i]). The sum is zero-extended to CNT_W, which cannot overflow given the parameter rule. pwm_out <= next_pwm every cycle.
- frame_start <= (fcnt == 0) & fcnt_changed_last_cycle. It is high exactly one clk per frame.
- Reset values: pwm_out=0, frame_start=0, wr_err=0, fcnt=FRAME_TICKS-1, shadow[i]=128 (center), pos_act=0, en_act=0.

## Timing
- clkdiv rise sampled at clk edge k: fcnt updates at edge k. pwm_out and frame_start reflect the new fcnt at edge k+1, a 1-clk latency from tick to output.
- Pulse width is exactly (BASE_TICKS + pos) ticks: it rises at frame start and falls on the tick where fcnt reaches BASE_TICKS+pos. With pos=0 the width is BASE_TICKS ticks. With pos=255 it is BASE_TICKS+255.
- en and shadow changes mid-frame do not affect the current pulse.
- Ticks are never lost. clkdiv must stay low at least 1 clk between rises, which the divider guarantees.
- rst_n low mid-frame forces all outputs low immediately (asynchronously). After release, the first tick starts a new frame with shadow=128 for all channels and the en value sampled then.

## Test plan
- Fast bench: FRAME_TICKS=400, BASE_TICKS=64, clkdiv toggling every clk (a tick every 2 clk).
- Reset, en=all 1, no writes -> from the first frame every channel is high for 64+128=192 ticks (384 clk), then low for 208 ticks. frame_start pulses every 800 clk, aligned with the pwm rising edge.
- Write ch0=0, ch1=255, ch7=10 mid-frame -> the current frame is unchanged. The next frame gives widths of 64, 319 and 74 ticks.
- Write ch2=200 in the exact boundary cycle -> that frame keeps the old width of 192 ticks. The following frame gives 264 ticks.
- wr_ch=7 with N_CH=6 -> wr_err high for 1 clk and all channel widths unchanged.
- Drop en[3] mid-frame -> ch3 completes its current pulse and stays low from the next frame. Re-assert en[3] -> pulses resume at the next boundary.
- Assert rst_n low for 3 clk in the middle of a pulse -> pwm_out=0 at once. After release, with clkdiv high, there is no tick until clkdiv's next rise, then widths are 192 ticks.
